// File: rtl/cordic_result_fifo_if.sv
// Handshake bundle between the CORDIC result FIFO and its producer/consumer.
// master drives push/pop/clear requests; slave is the FIFO itself.
interface cordic_result_fifo_if #(
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 4
);
   logic                  wr_en;
   logic [DATA_W-1:0]     wr_data;
   logic                  rd_en;
   logic [DATA_W-1:0]     rd_data;
   logic                  empty;
   logic                  full;
   logic [DEPTH_LOG2:0]   count;
   logic                  overflow;
   logic                  underflow;
   logic                  err_clr;

   modport master (
      output wr_en, wr_data, rd_en, err_clr,
      input  rd_data, empty, full, count, overflow, underflow
   );

   modport slave (
      input  wr_en, wr_data, rd_en, err_clr,
      output rd_data, empty, full, count, overflow, underflow
   );
endinterface

// File: rtl/cordic_result_fifo.sv
// Result buffer between CORDIC core output and the AHB-Lite slave read path.
// Define CORDIC_FIFO_FWFT_EN for first-word-fall-through; default is registered read.
module cordic_result_fifo #(
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   cordic_result_fifo_if.slave bus
);
   localparam int DEPTH = 2 ** DEPTH_LOG2;

   logic [DEPTH_LOG2:0] wr_ptr;
   logic [DEPTH_LOG2:0] rd_ptr;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic                ovf_q;
   logic                udf_q;

   logic                empty_now;
   logic                full_now;
   logic                do_wr;
   logic                do_rd;
   logic                ovf_set;
   logic                udf_set;

   // A write into a full FIFO is allowed when a pop frees the head slot in the same cycle.
   always_comb begin
      empty_now = (wr_ptr == rd_ptr);
      full_now  = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                  (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
      do_rd     = bus.rd_en && !empty_now;
      do_wr     = bus.wr_en && (!full_now || bus.rd_en);
      ovf_set   = bus.wr_en && full_now && !bus.rd_en;
      udf_set   = bus.rd_en && empty_now;
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         ovf_q <= (ovf_q && !bus.err_clr) || ovf_set;
         udf_q <= (udf_q && !bus.err_clr) || udf_set;
      end
   end

   always_ff @(posedge HCLK) begin
      if (do_wr) mem[wr_ptr[DEPTH_LOG2-1:0]] <= bus.wr_data;
   end

`ifdef CORDIC_FIFO_FWFT_EN
   assign bus.rd_data = empty_now ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];
`else
   logic [DATA_W-1:0] rd_q;

   always_ff @(posedge HCLK) begin
      if (!HRESETn)   rd_q <= '0;
      else if (do_rd) rd_q <= mem[rd_ptr[DEPTH_LOG2-1:0]];
   end

   assign bus.rd_data = rd_q;
`endif

   assign bus.empty     = empty_now;
   assign bus.full      = full_now;
   assign bus.count     = wr_ptr - rd_ptr;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = udf_q;
endmodule

// File: tb/tb_cordic_result_fifo.sv
// Self-checking bench for cordic_result_fifo: queue reference model plus directed/random stimulus.
module tb_cordic_result_fifo;
   localparam int DATA_W     = 32;
   localparam int DEPTH_LOG2 = 4;
   localparam int DEPTH      = 16;

   logic HCLK    = 1'b0;
   logic HRESETn = 1'b0;

   cordic_result_fifo_if #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

   cordic_result_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus)
   );

   always #5 HCLK = ~HCLK;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   logic [DATA_W-1:0] q [$];
   logic              m_ovf = 1'b0;
   logic              m_udf = 1'b0;
   logic [DATA_W-1:0] m_rd  = '0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: plain queue, decisions taken from occupancy before the edge.
   always @(posedge HCLK) begin
      bit e, f;
      if (!HRESETn) begin
         q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         m_rd  = '0;
      end else begin
         e = (q.size() == 0);
         f = (q.size() == DEPTH);
         if (bus.rd_en && !e) m_rd = q.pop_front();
         if (bus.wr_en && (!f || bus.rd_en)) q.push_back(bus.wr_data);
         m_ovf = (m_ovf && !bus.err_clr) || (bus.wr_en && f && !bus.rd_en);
         m_udf = (m_udf && !bus.err_clr) || (bus.rd_en && e);
      end
   end

   always @(negedge HCLK) begin
      logic [DATA_W-1:0] exp_rd;
      if (chk_en) begin
`ifdef CORDIC_FIFO_FWFT_EN
         exp_rd = (q.size() != 0) ? q[0] : '0;
`else
         exp_rd = m_rd;
`endif
         check("mdl_empty",     bus.empty,     q.size() == 0);
         check("mdl_full",      bus.full,      q.size() == DEPTH);
         check("mdl_count",     bus.count,     q.size());
         check("mdl_overflow",  bus.overflow,  m_ovf);
         check("mdl_underflow", bus.underflow, m_udf);
         check("mdl_rd_data",   bus.rd_data,   exp_rd);
      end
   end

   task automatic drive(input logic w, input logic [DATA_W-1:0] d, input logic r, input logic c);
      bus.wr_en   = w;
      bus.wr_data = d;
      bus.rd_en   = r;
      bus.err_clr = c;
      @(negedge HCLK);
   endtask

   task automatic rd_chk(input string nm, input logic [DATA_W-1:0] exp);
`ifdef CORDIC_FIFO_FWFT_EN
      check(nm, bus.rd_data, exp);
      drive(1'b0, '0, 1'b1, 1'b0);
`else
      drive(1'b0, '0, 1'b1, 1'b0);
      check(nm, bus.rd_data, exp);
`endif
   endtask

`ifdef CORDIC_FIFO_FWFT_EN
   localparam logic [DATA_W-1:0] RD_AFTER_DRAIN = '0;
`else
   localparam logic [DATA_W-1:0] RD_AFTER_DRAIN = 32'd15;
`endif

   initial begin
      bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0; bus.err_clr = 1'b0;
      @(negedge HCLK);
      drive(1'b0, '0, 1'b0, 1'b0);
      chk_en  = 1'b1;
      check("rst_empty", bus.empty, 1'b1);
      check("rst_count", bus.count, 0);
      check("rst_rd_data", bus.rd_data, 0);
      HRESETn = 1'b1;

      // 1: three words in order, latency 0 (FWFT) or 1 (registered)
      drive(1'b1, 32'hA1, 1'b0, 1'b0);
      drive(1'b1, 32'hA2, 1'b0, 1'b0);
      drive(1'b1, 32'hA3, 1'b0, 1'b0);
      check("t1_count3", bus.count, 3);
      rd_chk("t1_rd_a1", 32'hA1);
      rd_chk("t1_rd_a2", 32'hA2);
      rd_chk("t1_rd_a3", 32'hA3);
      check("t1_count0", bus.count, 0);
      check("t1_empty",  bus.empty, 1'b1);

      // 2: fill, overflow, drain
      for (int i = 0; i < DEPTH; i++) drive(1'b1, i, 1'b0, 1'b0);
      check("t2_full",  bus.full,  1'b1);
      check("t2_count", bus.count, 16);
      drive(1'b1, 32'hDEAD, 1'b0, 1'b0);
      check("t2_overflow", bus.overflow, 1'b1);
      check("t2_count_hold", bus.count, 16);
      for (int i = 0; i < DEPTH; i++) rd_chk("t2_drain", i);

      // 3: underflow and error clearing
      drive(1'b0, '0, 1'b1, 1'b0);
      check("t3_underflow", bus.underflow, 1'b1);
      check("t3_rd_hold", bus.rd_data, RD_AFTER_DRAIN);
      check("t3_count", bus.count, 0);
      drive(1'b0, '0, 1'b0, 1'b1);
      check("t3_clr_ovf", bus.overflow, 1'b0);
      check("t3_clr_udf", bus.underflow, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b1);
      check("t3_clr_race", bus.underflow, 1'b1);
      drive(1'b0, '0, 1'b0, 1'b1);

      // 4: simultaneous push/pop on a full FIFO
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 32'h100 + i, 1'b0, 1'b0);
      drive(1'b1, 32'hBEEF, 1'b1, 1'b0);
      check("t4_count", bus.count, 16);
      check("t4_no_ovf", bus.overflow, 1'b0);
      for (int i = 0; i < DEPTH; i++)
         rd_chk("t4_drain", (i == DEPTH - 1) ? 32'hBEEF : 32'h101 + i);

      // 5: steady occupancy of 5 with concurrent traffic across pointer wrap
      for (int i = 0; i < 5; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) drive(1'b1, $urandom, 1'b1, 1'b0);
      check("t5_count", bus.count, 5);
      for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 300; i++)
         drive(1'(($urandom & 3) != 0), $urandom, 1'($urandom & 1), 1'(($urandom & 7) == 0));

      // 6: reset mid-operation
      HRESETn = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0);
      HRESETn = 1'b1;
      drive(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b1, 32'hC0 + i, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b0);
      drive(1'b1, 32'hC5, 1'b0, 1'b0);
      check("t6_pre_count", bus.count, 5);
      check("t6_pre_udf", bus.underflow, 1'b1);
      HRESETn = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0);
      HRESETn = 1'b1;
      check("t6_empty", bus.empty, 1'b1);
      check("t6_count", bus.count, 0);
      check("t6_ovf", bus.overflow, 1'b0);
      check("t6_udf", bus.underflow, 1'b0);
      check("t6_rd_data", bus.rd_data, 0);
      drive(1'b0, '0, 1'b0, 1'b0);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
